// File: rtl/game_pkg.sv
// Shared types and default timing constants for the game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    MENU    = 2'd0,
    PLAY    = 2'd1,
    DEATH   = 2'd2,
    VICTORY = 2'd3
  } game_state_t;

  typedef logic [3:0] bcd_t;

  localparam int DEATH_TICKS_DEF = 24;
  localparam int MENU_TICKS_DEF  = 12;
  localparam int ATTEMPT_MAX_DEF = 99;

endpackage

// File: rtl/bcd_attempt_counter.sv
// Two-digit BCD attempt counter with synchronous clear and saturation at ATTEMPT_MAX.
module bcd_attempt_counter
  import game_pkg::*;
#(
  parameter int ATTEMPT_MAX = ATTEMPT_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t ones,
  output bcd_t tens,
  output logic max
);

  localparam bcd_t MAX_ONES = bcd_t'(ATTEMPT_MAX % 10);
  localparam bcd_t MAX_TENS = bcd_t'(ATTEMPT_MAX / 10);

  bcd_t ones_nxt;
  bcd_t tens_nxt;
  logic at_max;

  assign at_max = (ones == MAX_ONES) && (tens == MAX_TENS);

  always_comb begin
    ones_nxt = ones;
    tens_nxt = tens;
    if (ones == 4'd9) begin
      ones_nxt = 4'd0;
      tens_nxt = tens + 4'd1;
    end else begin
      ones_nxt = ones + 4'd1;
    end
  end

  // Once the count sits at the maximum, further increments are swallowed.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ones <= 4'd0;
      tens <= 4'd0;
      max  <= 1'b0;
    end else if (inc && !at_max) begin
      ones <= ones_nxt;
      tens <= tens_nxt;
      max  <= (ones_nxt == MAX_ONES) && (tens_nxt == MAX_TENS);
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: MENU -> PLAY -> DEATH/VICTORY, attempt tracking and screen controls.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int DEATH_TICKS = DEATH_TICKS_DEF,
  parameter int MENU_TICKS  = MENU_TICKS_DEF,
  parameter int ATTEMPT_MAX = ATTEMPT_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       collision,
  input  logic       level_done,
  output logic       menu_screen,
  output logic       play_en,
  output logic       player_death,
  output logic       victory_screen,
  output logic       reset_obj_count,
  output logic [3:0] attempts_ones,
  output logic [3:0] attempts_tens,
  output logic       attempts_max
);

  game_state_t state;
  game_state_t state_next;
  logic        start_q;
  logic        start_rise;
  logic [5:0]  tick_cnt;
  logic        obj_rst_next;
  logic        att_clr;
  logic        att_inc;

  assign start_rise = start_btn & ~start_q;

  always_comb begin
    state_next   = state;
    obj_rst_next = 1'b0;
    att_clr      = 1'b0;
    att_inc      = 1'b0;
    case (state)
      MENU: begin
        if (start_rise && (tick_cnt >= 6'(MENU_TICKS))) begin
          state_next   = PLAY;
          obj_rst_next = 1'b1;
          att_clr      = 1'b1;
        end
      end
      // level_done outranks collision when both land on the same tick.
      PLAY: begin
        if (tick) begin
          if (level_done) begin
            state_next = VICTORY;
          end else if (collision) begin
            state_next = DEATH;
            att_inc    = 1'b1;
          end
        end
      end
      DEATH: begin
        if (tick && (tick_cnt == 6'(DEATH_TICKS - 1))) begin
          state_next   = PLAY;
          obj_rst_next = 1'b1;
        end
      end
      VICTORY: begin
        if (start_rise) state_next = MENU;
      end
      default: state_next = MENU;
    endcase
  end

  // Flags are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= MENU;
      start_q         <= 1'b0;
      tick_cnt        <= 6'd0;
      reset_obj_count <= 1'b0;
      menu_screen     <= 1'b1;
      play_en         <= 1'b0;
      player_death    <= 1'b0;
      victory_screen  <= 1'b0;
    end else begin
      state           <= state_next;
      start_q         <= start_btn;
      reset_obj_count <= obj_rst_next;
      menu_screen     <= (state_next == MENU);
      play_en         <= (state_next == PLAY);
      player_death    <= (state_next == DEATH);
      victory_screen  <= (state_next == VICTORY);
      if (state_next != state) begin
        tick_cnt <= 6'd0;
      end else if (tick && (tick_cnt != 6'd63)) begin
        tick_cnt <= tick_cnt + 6'd1;
      end
    end
  end

  bcd_attempt_counter #(
    .ATTEMPT_MAX(ATTEMPT_MAX)
  ) u_attempts (
    .clk  (clk),
    .reset(reset),
    .clr  (att_clr),
    .inc  (att_inc),
    .ones (attempts_ones),
    .tens (attempts_tens),
    .max  (attempts_max)
  );

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl against a cycle-level behavioural game model.
module tb_game_flow_ctrl;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start_btn;
  logic       collision;
  logic       level_done;
  logic       menu_screen;
  logic       play_en;
  logic       player_death;
  logic       victory_screen;
  logic       reset_obj_count;
  logic [3:0] attempts_ones;
  logic [3:0] attempts_tens;
  logic       attempts_max;

  int checks = 0;
  int errors = 0;

  // Model state: which screen we are on, ticks spent there, attempts as a plain integer.
  string m_screen;
  int    m_ticks;
  int    m_attempts;
  bit    m_prev_start;
  bit    m_obj_pulse;
  int    saw_saturation;
  int    saw_victory;

  game_flow_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .tick           (tick),
    .start_btn      (start_btn),
    .collision      (collision),
    .level_done     (level_done),
    .menu_screen    (menu_screen),
    .play_en        (play_en),
    .player_death   (player_death),
    .victory_screen (victory_screen),
    .reset_obj_count(reset_obj_count),
    .attempts_ones  (attempts_ones),
    .attempts_tens  (attempts_tens),
    .attempts_max   (attempts_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit t, input bit sb, input bit col, input bit ld);
    reset      = r;
    tick       = t;
    start_btn  = sb;
    collision  = col;
    level_done = ld;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic modelStep();
    string next_screen;
    bit    pressed;
    if (reset) begin
      m_screen     = "MENU";
      m_ticks      = 0;
      m_attempts   = 0;
      m_prev_start = 0;
      m_obj_pulse  = 0;
      return;
    end
    pressed      = start_btn && !m_prev_start;
    m_prev_start = start_btn;
    m_obj_pulse  = 0;
    next_screen  = m_screen;
    if (m_screen == "MENU") begin
      if (pressed && m_ticks >= 12) begin
        next_screen = "PLAY";
        m_obj_pulse = 1;
        m_attempts  = 0;
      end
    end else if (m_screen == "PLAY") begin
      if (tick && level_done) begin
        next_screen = "VICTORY";
        saw_victory++;
      end else if (tick && collision) begin
        next_screen = "DEATH";
        if (m_attempts < 99) m_attempts++;
        else saw_saturation++;
      end
    end else if (m_screen == "DEATH") begin
      if (tick && m_ticks + 1 == 24) begin
        next_screen = "PLAY";
        m_obj_pulse = 1;
      end
    end else begin
      if (pressed) next_screen = "MENU";
    end
    if (next_screen != m_screen) m_ticks = 0;
    else if (tick && m_ticks < 63) m_ticks++;
    m_screen = next_screen;
  endtask

  task automatic checkAll();
    checkOutput("menu_screen",     32'(menu_screen),     32'(m_screen == "MENU"));
    checkOutput("play_en",         32'(play_en),         32'(m_screen == "PLAY"));
    checkOutput("player_death",    32'(player_death),    32'(m_screen == "DEATH"));
    checkOutput("victory_screen",  32'(victory_screen),  32'(m_screen == "VICTORY"));
    checkOutput("reset_obj_count", 32'(reset_obj_count), 32'(m_obj_pulse));
    checkOutput("attempts_ones",   32'(attempts_ones),   32'(m_attempts % 10));
    checkOutput("attempts_tens",   32'(attempts_tens),   32'(m_attempts / 10));
    checkOutput("attempts_max",    32'(attempts_max),    32'(m_attempts == 99));
  endtask

  // One cycle: drive at negedge, let the model and DUT see the same posedge, check at next negedge.
  task automatic runPhase(input int cycles, input int p_tick, input int p_col, input int p_ld,
                          input int p_start, input int p_reset);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(($urandom_range(999) < 32'(p_reset)),
                    ($urandom_range(99) < 32'(p_tick)),
                    ($urandom_range(99) < 32'(p_start)),
                    ($urandom_range(99) < 32'(p_col)),
                    ($urandom_range(99) < 32'(p_ld)));
      modelStep();
      @(negedge clk);
      checkAll();
    end
  endtask

  initial begin
    saw_saturation = 0;
    saw_victory    = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    modelStep();
    @(negedge clk);
    checkAll();
    // Exercise menu start guard: start pressed well before 12 ticks, then held-off presses.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      modelStep();
      @(negedge clk);
      checkAll();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    modelStep();
    @(negedge clk);
    checkAll();
    runPhase(3000, 60, 20, 8, 40, 3);
    runPhase(9000, 70, 85, 0, 50, 0);
    runPhase(3000, 50, 25, 15, 40, 4);
    runPhase(2000, 100, 50, 5, 50, 2);
    $display("[TB] info: victories %0d, saturated increments %0d", saw_victory, saw_saturation);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Central game sequencer between the level/collision logic and the display datapath. FSM MENU -> PLAY -> DEATH -> PLAY ... -> VICTORY -> MENU, run at game-tick rate through a tick strobe. Owns the two-digit BCD attempt counter feeding the seven-segment decoders and the saturation LED. Drives the screen-select and object-counter-reset controls consumed by the VGA and object-position blocks.

Parameters:
DEATH_TICKS, 24, game ticks spent in DEATH (death animation) before auto-restart
MENU_TICKS, 12, minimum game ticks in MENU before start_btn is accepted (debounce guard)
ATTEMPT_MAX, 99, attempt count saturation value (BCD 9/9)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high reset
tick  in  1  one-clk strobe at game-clock rate (from the slow-clock divider)
start_btn  in  1  level, active-high (inverted KEY), player start/jump
collision  in  1  level, player-obstacle hit from level logic
level_done  in  1  level, end-of-level reached
menu_screen  out  1  high in MENU
play_en  out  1  high in PLAY; gates object motion and jump logic
player_death  out  1  high in DEATH
victory_screen  out  1  high in VICTORY
reset_obj_count  out  1  one-clk pulse: restart object position counter
attempts_ones  out  4  BCD ones digit of attempts
attempts_tens  out  4  BCD tens digit of attempts
attempts_max  out  1  high while attempts == ATTEMPT_MAX (LEDG)

Behaviour:
- One clock, synchronous active-high reset. On reset: state MENU, menu_screen=1, other state flags 0, reset_obj_count=0, both digits 0, attempts_max=0, tick counter 0, start edge register 0.
- State flags are one-hot and registered; exactly one is high at any time.
- start_btn: registered every clk; rise = start_btn & ~start_q. Rises not coinciding with an accepting state/tick condition are discarded (no queueing).
- tick counter: 6 bits; cleared on every state change, incremented on tick, saturates at 63.
- MENU: start rise with tick counter >= MENU_TICKS -> PLAY at that clk; reset_obj_count pulses the same clk; attempts cleared to 00.
- PLAY: evaluated only on clks with tick=1. level_done=1 -> VICTORY. Else collision=1 -> DEATH and attempts increment in the same clk. Both high on one tick: level_done wins, no increment. collision/level_done without tick are ignored.
- DEATH: on the tick where tick counter reaches DEATH_TICKS-1 -> PLAY, with reset_obj_count pulse. start_btn ignored. collision ignored.
- VICTORY: attempts frozen (displayed). start rise -> MENU. Attempts cleared on MENU->PLAY, not on entry to VICTORY.
- Attempt increment: ones 0..9; ones==9 -> ones=0, tens+1. At 9/9 count holds (saturates); attempts_max=1 from the clk the count becomes 9/9 until next clear. Digits never leave 0..9.
- Latency: all outputs registered, one clk after the triggering condition.
- reset asserted mid-state: next clk returns to reset values regardless of state or pending pulse.
- tick high on consecutive clks is legal; each is treated as a separate tick.

Decomposition:
- Package game_pkg: enum game_state_t {MENU, PLAY, DEATH, VICTORY} (2-bit), DEATH_TICKS/MENU_TICKS defaults, BCD digit typedef bcd_t (logic [3:0]).
- One sub-module: bcd_attempt_counter (clk, reset, clr, inc -> ones, tens, max) with saturation; FSM, tick counter and edge detect stay in game_flow_ctrl.

Test Plan:
- reset, 12 ticks, start rise -> PLAY next clk, reset_obj_count one-clk pulse, attempts 0/0; start rise after 5 ticks in MENU -> stays MENU.
- PLAY, collision on tick -> DEATH, attempts 0/1; 24 ticks later -> PLAY with reset_obj_count pulse; collision held without tick -> no change.
- 9 deaths then 1 more -> ones 0, tens 1; 99 deaths then 1 more -> stays 9/9, attempts_max=1.
- PLAY, collision and level_done same tick -> VICTORY, attempts unchanged, player_death never 1.
- VICTORY with attempts 0/3, start rise -> MENU, digits still 0/3; next MENU->PLAY -> 0/0.
- reset asserted in DEATH mid-hold -> next clk MENU, digits 0/0, all pulses 0.
